// File: rtl/rv32_pkg.sv
// Shared fetch-side definitions: NOP encoding, default reset vector, fetch FSM states, FIFO entry.
// Latency: none (types and constants only).
// Backpressure: none (types and constants only).
package rv32_pkg;

  // addi x0, x0, 0 -- what decode sees while no real instruction is available
  localparam logic [31:0] NOP_INST         = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // IDLE: nothing outstanding; WAIT: outstanding, keep the result; DROP: outstanding, discard it
  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_WAIT = 2'd1,
    FETCH_DROP = 2'd2
  } fetchState_e;

  // One buffered instruction with the address it was fetched from
  typedef struct packed {
    logic [31:0] word;
    logic [31:0] pc;
  } fetchEntry_t;

  // Instructions are word aligned; the low two address bits are forced to zero
  function automatic logic [31:0] alignPc(input logic [31:0] pc);
    return pc & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry instruction buffer holding {word, pc}; head is the oldest entry.
// Latency: a pushed entry is visible at head one cycle after the push edge.
// Backpressure: none internally; the producer must not push when full unless popping the same cycle.
module fetch_fifo
  import rv32_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic        pop,
  input  logic        flush,
  input  fetchEntry_t pushEntry,
  output logic [1:0]  count,
  output fetchEntry_t head
);

  fetchEntry_t slots [0:1];
  logic        rdPtr;
  logic [1:0]  cnt;
  logic        wrPtr;
  logic        doPush;
  logic        doPop;

  // Write slot follows the read pointer by the occupancy; when full and popping,
  // the new entry lands in the slot being vacated.
  always_comb begin
    wrPtr  = rdPtr ^ cnt[0];
    doPop  = pop && (cnt != 2'd0);
    doPush = push && ((cnt != 2'd2) || doPop);
  end

  // Occupancy and read pointer; a flush empties the buffer regardless of push/pop
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= 2'd0;
      rdPtr <= 1'b0;
    end else if (flush) begin
      cnt   <= 2'd0;
      rdPtr <= 1'b0;
    end else begin
      cnt <= cnt + {1'b0, doPush} - {1'b0, doPop};
      if (doPop) begin
        rdPtr <= ~rdPtr;
      end
    end
  end

  // Payload storage; contents are don't-care while the slot is not occupied
  always_ff @(posedge clk) begin
    if (!rst && !flush && doPush) begin
      slots[wrPtr] <= pushEntry;
    end
  end

  assign count = cnt;
  assign head  = slots[rdPtr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding imem request, 2-entry {word, pc} buffer, redirect handling.
// Latency: redirect to first request 1 cycle when idle; ack to buffer head 1 cycle; back-to-back issue on ack.
// Backpressure: stall holds the head; requests stop while buffered + outstanding would reach 2 entries.
module fetch_unit
  import rv32_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        pcSel,
  input  logic [31:0] pcTarget,
  input  logic        stall,
  output logic [31:0] inst,
  output logic [31:0] instPc,
  output logic        instValid
);

  fetchState_e state;
  fetchState_e stateNext;
  logic [31:0] fetchPc;        // next address to request
  logic [31:0] fetchPcNext;
  logic        reqNext;
  logic [31:0] addrNext;

  // Set when reset interrupted an outstanding request: the memory still owes one
  // ack for it, and that ack must not be mistaken for the answer to a new request.
  logic        staleOut;
  logic        effAck;

  logic        fifoPush;
  logic        fifoPop;
  logic        fifoFlush;
  logic [1:0]  fifoCount;
  fetchEntry_t fifoHead;
  fetchEntry_t fifoIn;
  logic [2:0]  countAfter;
  logic [31:0] targetPc;
  logic        doIssue;
  logic [31:0] issueAddr;

  fetch_fifo u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifoPush),
    .pop       (fifoPop),
    .flush     (fifoFlush),
    .pushEntry (fifoIn),
    .count     (fifoCount),
    .head      (fifoHead)
  );

  // Buffer control: redirect flushes and overrides stall/pop; only kept results are pushed
  always_comb begin
    effAck     = imem_ack && !staleOut;
    targetPc   = alignPc(pcTarget);
    fifoFlush  = pcSel;
    fifoPop    = instValid && !stall && !pcSel;
    fifoPush   = (state == FETCH_WAIT) && effAck && !pcSel;
    fifoIn     = '{word: imem_rdata, pc: imem_addr};
    countAfter = pcSel ? 3'd0
                       : ({1'b0, fifoCount} + {2'b00, fifoPush} - {2'b00, fifoPop});
  end

  // Next-state and request logic; issue only when the buffer can absorb the answer
  always_comb begin
    stateNext   = state;
    fetchPcNext = fetchPc;
    reqNext     = imem_req;
    addrNext    = imem_addr;
    doIssue     = 1'b0;
    issueAddr   = fetchPc;

    case (state)
      FETCH_IDLE: begin
        if (pcSel) begin
          doIssue   = 1'b1;
          issueAddr = targetPc;
        end else if (countAfter < 3'd2) begin
          doIssue   = 1'b1;
          issueAddr = fetchPc;
        end
      end

      FETCH_WAIT: begin
        if (effAck) begin
          if (pcSel) begin
            // acked word belongs to the old path: drop it and chase the target now
            doIssue   = 1'b1;
            issueAddr = targetPc;
          end else if (countAfter < 3'd2) begin
            doIssue   = 1'b1;
            issueAddr = fetchPc;
          end else begin
            stateNext = FETCH_IDLE;
            reqNext   = 1'b0;
          end
        end else if (pcSel) begin
          // request cannot be withdrawn; remember to throw its answer away
          stateNext   = FETCH_DROP;
          fetchPcNext = targetPc;
        end
      end

      FETCH_DROP: begin
        if (pcSel) begin
          fetchPcNext = targetPc;
        end
        if (effAck) begin
          stateNext = FETCH_IDLE;
          reqNext   = 1'b0;
        end
      end

      default: begin
        stateNext = FETCH_IDLE;
        reqNext   = 1'b0;
      end
    endcase

    if (doIssue) begin
      stateNext   = FETCH_WAIT;
      reqNext     = 1'b1;
      addrNext    = issueAddr;
      fetchPcNext = issueAddr + 32'd4;
    end
  end

  // State, fetch pc and registered request outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FETCH_IDLE;
      fetchPc   <= RESET_PC;
      imem_req  <= 1'b0;
      imem_addr <= 32'h0000_0000;
    end else begin
      state     <= stateNext;
      fetchPc   <= fetchPcNext;
      imem_req  <= reqNext;
      imem_addr <= addrNext;
    end
  end

  // Track the one ack still owed for a request that reset cut short
  always_ff @(posedge clk) begin
    if (rst) begin
      staleOut <= !imem_ack && (staleOut || (state != FETCH_IDLE));
    end else if (imem_ack) begin
      staleOut <= 1'b0;
    end
  end

  // Decode sees the buffer head, or a NOP at pc 0 while the buffer is empty
  always_comb begin
    instValid = (fifoCount != 2'd0);
    inst      = instValid ? fifoHead.word : NOP_INST;
    instPc    = instValid ? fifoHead.pc   : 32'h0000_0000;
  end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
  import rv32_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imemAck = 1'b0;
  logic [31:0] imemRdata = 32'h0;
  logic        pcSel = 1'b0;
  logic [31:0] pcTarget = 32'h0;
  logic        stall = 1'b0;
  logic [31:0] inst;
  logic [31:0] instPc;
  logic        instValid;

  // second instance: wrap-around reset vector, memory answers in the request cycle
  logic        req1;
  logic [31:0] addr1;
  logic        ack1;
  logic [31:0] rdata1;
  logic [31:0] inst1;
  logic [31:0] instPc1;
  logic        instValid1;
  logic        pcSel1 = 1'b0;
  logic [31:0] pcTarget1 = 32'h0;
  logic        stall1 = 1'b0;

  int nChecks = 0;
  int nFail = 0;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imemAck), .imem_rdata(imemRdata), .pcSel(pcSel), .pcTarget(pcTarget),
    .stall(stall), .inst(inst), .instPc(instPc), .instValid(instValid)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dutWrap (
    .clk(clk), .rst(rst), .imem_req(req1), .imem_addr(addr1),
    .imem_ack(ack1), .imem_rdata(rdata1), .pcSel(pcSel1), .pcTarget(pcTarget1),
    .stall(stall1), .inst(inst1), .instPc(instPc1), .instValid(instValid1)
  );

  assign ack1   = req1;
  assign rdata1 = addr1;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- memory model: one request at a time, fixed latency ----------------
  int          memLat = 1;
  int          memCnt = 0;
  bit          memPend = 0;
  logic [31:0] memAddr = 32'h0;

  always @(negedge clk) begin
    if (imemAck) begin
      imemAck   = 1'b0;
      imemRdata = 32'hBAD0_BAD0;
      memPend   = 1'b0;
    end
    if (!memPend && imem_req) begin
      memPend = 1'b1;
      memCnt  = memLat - 1;
      memAddr = imem_addr;
    end else if (memPend && memCnt > 0) begin
      memCnt--;
    end
    if (memPend && memCnt == 0) begin
      imemAck   = 1'b1;
      imemRdata = memWord(memAddr);
    end
  end

  // ---------------- scoreboard and request-stability monitor ----------------
  logic [31:0] expQ[$];
  bit          sbOn = 0;
  logic [31:0] monE;
  logic        prevReq = 1'b0;
  logic        prevAck = 1'b0;
  logic        prevRst = 1'b1;
  logic [31:0] prevAddr = 32'h0;

  always @(negedge clk) begin
    #2;
    if (sbOn && !rst && instValid && !stall && !pcSel) begin
      if (expQ.size() == 0) begin
        nChecks++;
        nFail++;
        $display("FAIL sb_unexpected: got pc %h, none expected", instPc);
      end else begin
        monE = expQ.pop_front();
        check32("sb_pc", instPc, monE);
        check32("sb_inst", inst, memWord(monE));
      end
    end
    if (prevReq && !prevAck && !prevRst) begin
      check32("req_held", {31'b0, imem_req}, 32'd1);
      check32("addr_held", imem_addr, prevAddr);
    end
    prevReq  = imem_req;
    prevAck  = imemAck;
    prevRst  = rst;
    prevAddr = imem_addr;
  end

  // ---------------- helpers ----------------
  task automatic seqReset(input int lat);
    @(negedge clk);
    rst = 1'b1; stall = 1'b1; pcSel = 1'b0; memLat = lat;
    @(negedge clk);
    rst = 1'b0; stall = 1'b0;
  endtask

  task automatic waitReq(input logic [31:0] addr);
    bit ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk); #1;
      if (imem_req && imem_addr == addr) ok = 1;
    end
    nChecks++;
    if (!ok) begin
      nFail++;
      $display("FAIL wait_req: no request to %h within budget", addr);
    end
  endtask

  task automatic drain();
    bit ok = 0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (expQ.size() == 0) ok = 1;
    end
    stall = 1'b1;
    sbOn  = 0;
    check32("sb_drained", expQ.size(), 0);
    expQ.delete();
  endtask

  // ---------------- table of per-cycle vectors ----------------
  typedef struct packed {
    logic        rst;
    logic        stall;
    logic        expReq;
    logic [31:0] expAddr;
    logic        expValid;
    logic [31:0] expPc;
    logic        chk1;
    logic [31:0] exp1Addr;
  } vec_t;

  vec_t vecs [0:17];

  initial begin
    logic [31:0] seen;
    bit ok;

    vecs[0]  = '{1'b1, 1'b0, 1'b0, 32'h0,  1'b0, 32'h0, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 32'h0, 1'b0, 32'h0};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 32'h0,  1'b0, 32'h0, 1'b1, 32'hFFFF_FFF8};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 32'h4,  1'b1, 32'h0, 1'b1, 32'hFFFF_FFFC};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 32'h8,  1'b1, 32'h4, 1'b1, 32'h0};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 32'hC,  1'b1, 32'h8, 1'b0, 32'h0};
    vecs[6]  = '{1'b1, 1'b0, 1'b1, 32'h10, 1'b1, 32'hC, 1'b0, 32'h0};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 32'h0, 1'b0, 32'h0};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 32'h0,  1'b0, 32'h0, 1'b1, 32'hFFFF_FFF8};
    vecs[9]  = '{1'b0, 1'b1, 1'b1, 32'h4,  1'b1, 32'h0, 1'b1, 32'hFFFF_FFFC};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 32'h4,  1'b1, 32'h0, 1'b1, 32'h0};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 32'h4,  1'b1, 32'h0, 1'b0, 32'h0};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 32'h4,  1'b1, 32'h0, 1'b0, 32'h0};
    vecs[13] = '{1'b0, 1'b1, 1'b0, 32'h4,  1'b1, 32'h0, 1'b0, 32'h0};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 32'h4,  1'b1, 32'h0, 1'b0, 32'h0};
    vecs[15] = '{1'b0, 1'b0, 1'b1, 32'h8,  1'b1, 32'h4, 1'b0, 32'h0};
    vecs[16] = '{1'b0, 1'b0, 1'b1, 32'hC,  1'b1, 32'h8, 1'b0, 32'h0};
    vecs[17] = '{1'b0, 1'b1, 1'b1, 32'h10, 1'b1, 32'hC, 1'b0, 32'h0};

    repeat (2) @(negedge clk);

    // streaming, reset values, stall fill and release (memory latency 1)
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      rst   = vecs[i].rst;
      stall = vecs[i].stall;
      #2;
      check32($sformatf("v%0d_req", i), {31'b0, imem_req}, {31'b0, vecs[i].expReq});
      check32($sformatf("v%0d_addr", i), imem_addr, vecs[i].expAddr);
      check32($sformatf("v%0d_valid", i), {31'b0, instValid}, {31'b0, vecs[i].expValid});
      check32($sformatf("v%0d_pc", i), instPc, vecs[i].expPc);
      check32($sformatf("v%0d_inst", i), inst,
              vecs[i].expValid ? memWord(vecs[i].expPc) : 32'h0000_0013);
      if (vecs[i].chk1) begin
        check32($sformatf("v%0d_wrap_addr", i), addr1, vecs[i].exp1Addr);
      end
    end

    // redirect to 0x103 while the request to 0x8 is outstanding (latency 3)
    seqReset(3);
    expQ.push_back(32'h0); expQ.push_back(32'h4);
    expQ.push_back(32'h100); expQ.push_back(32'h104);
    sbOn = 1;
    waitReq(32'h8);
    @(negedge clk); #1;
    pcSel = 1'b1; pcTarget = 32'h0000_0103;
    @(negedge clk); #1;
    pcSel = 1'b0;
    ok = 0;
    seen = 32'h8;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (imem_req && imem_addr != 32'h8) begin
        ok = 1;
        seen = imem_addr;
      end else begin
        @(negedge clk); #1;
      end
    end
    check32("drop_next_req", seen, 32'h100);
    drain();

    // redirect to 0x200 in the same cycle as the ack for 0x8
    seqReset(3);
    expQ.push_back(32'h0); expQ.push_back(32'h4);
    expQ.push_back(32'h200); expQ.push_back(32'h204);
    sbOn = 1;
    waitReq(32'h8);
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk); #1;
      if (imemAck && imem_addr == 32'h8) ok = 1;
    end
    check32("ack8_seen", {31'b0, ok}, 32'd1);
    pcSel = 1'b1; pcTarget = 32'h0000_0200;
    @(negedge clk); #1;
    pcSel = 1'b0;
    check32("redir_req", {31'b0, imem_req}, 32'd1);
    check32("redir_addr", imem_addr, 32'h200);
    check32("redir_flushed", {31'b0, instValid}, 32'd0);
    drain();

    // reset while the request to 0x8 is outstanding, ack arrives after release (latency 5)
    seqReset(5);
    expQ.push_back(32'h0); expQ.push_back(32'h4);
    sbOn = 1;
    waitReq(32'h8);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    expQ.push_back(32'h0); expQ.push_back(32'h4);
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk); #1;
      if (instValid) ok = 1;
    end
    check32("rst_first_valid", {31'b0, ok}, 32'd1);
    check32("rst_first_pc", instPc, 32'h0);
    check32("rst_first_inst", inst, memWord(32'h0));
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, %0d checks so far", nChecks);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: RESET_PC, default 32'h0000_0000, address of the first fetch after reset.
REQ-002 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 Port: rst  input  1  synchronous, active-high reset.
REQ-004 Port: imem_req  output  1  instruction-memory request valid, registered.
REQ-005 Port: imem_addr  output  32  request address, word aligned, registered.
REQ-006 Port: imem_ack  input  1  memory response valid; one cycle per request; arrives one or more cycles after the request.
REQ-007 Port: imem_rdata  input  32  instruction word; valid only when imem_ack=1.
REQ-008 Port: pcSel  input  1  redirect request from control; 1 means take pcTarget.
REQ-009 Port: pcTarget  input  32  redirect address; bits [1:0] ignored and treated as 00.
REQ-010 Port: stall  input  1  decode hold; 1 means the current inst is not consumed.
REQ-011 Port: inst  output  32  instruction presented to control/decode.
REQ-012 Port: instPc  output  32  address of inst.
REQ-013 Port: instValid  output  1  inst/instPc hold a real fetched instruction.

Function
REQ-014 Only one memory request SHALL be outstanding at a time; imem_req and imem_addr SHALL stay stable from issue until the imem_ack cycle.
REQ-015 A 2-entry FIFO SHALL buffer {word, pc}; inst/instPc SHALL show the FIFO head; instValid = FIFO not empty.
REQ-016 When FIFO empty, inst SHALL be 32'h0000_0013 (NOP) and instPc SHALL be 0.
REQ-017 Pop SHALL occur when instValid=1 and stall=0 and pcSel=0.
REQ-018 A new request SHALL issue only when (FIFO count after this cycle's push/pop) + (outstanding after this cycle) < 2, so a push never hits a full FIFO.
REQ-019 On an imem_ack in state WAIT, the word SHALL be pushed with its imem_addr; if REQ-018 permits, imem_req SHALL stay 1 with imem_addr advanced by 4 at the next edge; this gives back-to-back issue.
REQ-020 Fetch pc SHALL advance by 4 modulo 2^32: 32'hFFFF_FFFC wraps to 32'h0000_0000.
REQ-021 State machine: IDLE (nothing outstanding), WAIT (outstanding, result kept), DROP (outstanding, result to be discarded).
REQ-022 IDLE -> WAIT on issue; WAIT -> IDLE on ack with no re-issue; WAIT -> WAIT on ack with re-issue; WAIT -> DROP on pcSel=1 without ack; DROP -> IDLE on ack (word discarded, not pushed).
REQ-023 pcSel=1 SHALL flush the FIFO in the same edge, set fetch pc to {pcTarget[31:2],2'b00}, and override stall and pop.
REQ-024 pcSel=1 in IDLE, or in WAIT with imem_ack=1: the acked word SHALL be discarded and a request to the target SHALL issue at the next edge (state WAIT).
REQ-025 pcSel=1 in DROP SHALL only update fetch pc to the newer target; state stays DROP.
REQ-026 Redirect-to-first-request latency SHALL be 1 cycle when nothing is outstanding after the redirect edge.

Reset
REQ-027 rst=1 SHALL set state IDLE, fetch pc RESET_PC, FIFO empty, imem_req 0, imem_addr 0, so instValid 0, inst NOP and instPc 0.
REQ-028 An outstanding request interrupted by reset SHALL have its late imem_ack ignored; the first request after reset SHALL be RESET_PC, issued on the first edge with rst=0.

Structure
REQ-029 Shared package rv32_pkg SHALL hold the NOP encoding, the default RESET_PC, and the fetch state enum.
REQ-030 The 2-entry FIFO SHALL be a sub-module fetch_fifo with ports push, pop, flush, count, head.

Verification
REQ-031 Reset, RESET_PC=0, memory latency 1 -> requests 0x0,0x4,0x8 on consecutive cycles; inst and instPc follow with instValid=1.
REQ-032 stall=1 held 5 cycles after the first instruction -> FIFO fills to 2, imem_req drops to 0, inst stays at pc 0x0; after stall release, 0x4 and 0x8 follow with no loss.
REQ-033 pcSel=1, pcTarget=0x103 while a request to 0x8 is outstanding (latency 3) -> the ack for 0x8 is discarded, the FIFO is flushed, the next request goes to 0x100, and instPc=0x100 is the next valid output.
REQ-034 pcSel=1 with pcTarget=0x200 in the same cycle as imem_ack for 0x8 -> 0x8 is never presented; the request to 0x200 issues at the next edge.
REQ-035 RESET_PC=0xFFFF_FFF8 -> requests 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
REQ-036 rst=1 during an outstanding request, with the ack arriving after rst=0 -> the stale word is not pushed, and the first valid instPc is RESET_PC.
